// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: exception codes (also used by decode), buffered entry, FSM states.
package fetch_pkg;

  localparam logic [5:0] EXC_INST_MISALIGNED   = 6'd0;
  localparam logic [5:0] EXC_INST_ACCESS_FAULT = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL_INST      = 6'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc_valid;
    logic [5:0]  exc_num;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [31:0] inst, input logic [31:0] pc,
                                              input logic exc_valid, input logic [5:0] exc_num);
    fetch_entry_t e;
    e.inst      = inst;
    e.pc        = pc;
    e.exc_valid = exc_valid;
    e.exc_num   = exc_num;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order response buffer of fetch entries; clear has priority and may coexist with a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_addr;

  // A clearing push lands in slot 0 so it becomes the new head.
  assign wr_addr = clear ? '0 : wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= CW'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage carries no reset; count alone decides validity, so this stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC issue with credit flow control, in-order response buffer, flush redirect.
// Optional FETCH_BYPASS_EN: a response into an empty buffer is presented in its arrival cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_error,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        fetch_stall,
  output logic [5:0]  exception_num_out,
  output logic        exception_valid_out,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          hold_q, hold_d;
  logic          started_q;

  logic          credit_ok, req_acc;
  logic          resp_take, resp_use, bypass, push_resp, flush_misaligned;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  resp_entry, mis_entry, fifo_data, fifo_head, present;
  logic          present_valid;

  // Credits cover requests in flight (live or to be dropped) plus buffered entries.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, drop_q} + {1'b0, fifo_count})
                     < (CW+1)'(FIFO_DEPTH);

  // A request that was offered but not yet taken stays up until memory accepts it.
  assign mem_req_valid = hold_q || (started_q && (state_q == ST_RUN) && credit_ok);
  assign mem_req_addr  = started_q ? pc_q : '0;
  assign req_acc       = mem_req_valid && mem_req_ready;

  assign flush_misaligned = (flush_pc[1:0] != 2'b00);

  // Responses for live requests; after an exception (HALT) they are consumed but discarded.
  assign resp_take = started_q && mem_resp_valid && !flush && (drop_q == '0);
  assign resp_use  = resp_take && (state_q == ST_RUN);

  assign resp_entry = mem_resp_error
                    ? make_entry(32'h0, resp_pc_q, 1'b1, EXC_INST_ACCESS_FAULT)
                    : make_entry(mem_resp_data, resp_pc_q, 1'b0, EXC_INST_MISALIGNED);
  assign mis_entry  = make_entry(32'h0, flush_pc, 1'b1, EXC_INST_MISALIGNED);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_use && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign present       = bypass ? resp_entry : fifo_head;
  assign present_valid = bypass || !fifo_empty;

  // A bypassed response only needs buffering when decode stalls it.
  assign push_resp = resp_use && !(bypass && !fetch_stall);
  assign fifo_push = flush ? flush_misaligned : push_resp;
  assign fifo_data = flush ? mis_entry : resp_entry;
  assign fifo_pop  = !flush && !fifo_empty && !fetch_stall;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .push     (fifo_push),
    .push_data(fifo_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    hold_d        = 1'b0;

    if (flush) begin
      // Everything still in flight becomes stale; a response landing now retires one of them.
      pc_d          = flush_pc;
      resp_pc_d     = flush_pc;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q + CW'(req_acc) - CW'(mem_resp_valid);
      state_d       = flush_misaligned ? ST_HALT : ST_RUN;
    end else begin
      if (req_acc)   pc_d      = pc_q + 32'd4;
      if (resp_take) resp_pc_d = resp_pc_q + 32'd4;
      hold_d        = mem_req_valid && !mem_req_ready;
      outstanding_d = outstanding_q + CW'(req_acc) - CW'(resp_take);
      drop_d        = drop_q - CW'(mem_resp_valid && (drop_q != '0));
      if (resp_use && mem_resp_error) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      hold_q        <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
      started_q     <= 1'b1;
    end
  end

  assign inst_valid          = present_valid;
  assign inst                = present_valid ? present.inst : '0;
  assign inst_pc             = present_valid ? present.pc : '0;
  assign exception_valid_out = present_valid && present.exc_valid;
  assign exception_num_out   = present_valid ? present.exc_num : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a PC-stream reference of deliveries.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_error = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid;
  logic        fetch_stall = 1'b0;
  logic [5:0]  exception_num_out;
  logic        exception_valid_out;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .mem_req_addr       (mem_req_addr),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_resp_data      (mem_resp_data),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_error     (mem_resp_error),
    .inst               (inst),
    .inst_pc            (inst_pc),
    .inst_valid         (inst_valid),
    .fetch_stall        (fetch_stall),
    .exception_num_out  (exception_num_out),
    .exception_valid_out(exception_valid_out),
    .flush              (flush),
    .flush_pc           (flush_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: in-order responses, one per accepted request, after a per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    inflight = 0;
  int    lat_min = 1, lat_max = 1;
  bit    rand_ready = 0, rand_stall = 0, stall_force = 0;
  bit    flush_req = 0;
  logic [31:0] flush_tgt = '0;
  bit    nop_mode = 1, err_en = 0;
  logic [31:0] err_addr = '0;

  // Reference: the decode side must see flush_pc, +4, +8 ... until an exception entry.
  logic [31:0] exp_pc, exp_req, last_deliv_pc;
  bit          exp_mis, exp_done;
  int          n_deliv = 0;
  bit          prev_stall_hold, prev_req_hold, post_flush_chk;
  logic [31:0] prev_pc, prev_inst, prev_addr;
  int          first_resp_cyc, first_iv_cyc;
  int          deliv_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : (a ^ 32'hC3A5_0013);
  endfunction

  task automatic model_reset();
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    exp_mis = 0;
    exp_done = 0;
    pend.delete();
    inflight = 0;
    prev_stall_hold = 0;
    prev_req_hold = 0;
    post_flush_chk = 0;
    first_resp_cyc = -1;
    first_iv_cyc = -1;
    deliv_cyc.delete();
  endtask

  task automatic sample();
    bit acc, xfer;
    acc  = mem_req_valid && mem_req_ready;
    xfer = inst_valid && !fetch_stall;
    if (prev_stall_hold) begin
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_pc", inst_pc, prev_pc);
      check("stall_inst", inst, prev_inst);
    end
    if (prev_req_hold) begin
      check("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
      check("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (post_flush_chk) check("flush_clears_valid", {31'b0, inst_valid}, 32'd0);
    if (inst_valid && first_iv_cyc < 0) first_iv_cyc = cyc;

    if (!flush) begin
      if (xfer) begin
        n_deliv++;
        deliv_cyc.push_back(cyc);
        last_deliv_pc = inst_pc;
        if (exp_done) begin
          check("extra_inst_valid", {31'b0, inst_valid}, 32'd0);
        end else if (exp_mis) begin
          check("mis_pc", inst_pc, exp_pc);
          check("mis_inst", inst, 32'd0);
          check("mis_exc_valid", {31'b0, exception_valid_out}, 32'd1);
          check("mis_exc_num", {26'b0, exception_num_out}, 32'd0);
          exp_done = 1;
        end else if (err_en && exp_pc == err_addr) begin
          check("fault_pc", inst_pc, exp_pc);
          check("fault_inst", inst, 32'd0);
          check("fault_exc_valid", {31'b0, exception_valid_out}, 32'd1);
          check("fault_exc_num", {26'b0, exception_num_out}, 32'd1);
          exp_done = 1;
        end else begin
          check("inst_pc", inst_pc, exp_pc);
          check("inst", inst, mem_word(exp_pc));
          check("inst_exc_valid", {31'b0, exception_valid_out}, 32'd0);
          exp_pc += 32'd4;
        end
      end
      if (acc) begin
        if (exp_mis) check("mis_no_req", {31'b0, mem_req_valid}, 32'd0);
        else check("req_addr", mem_req_addr, exp_req);
        exp_req += 32'd4;
      end
    end

    if (acc) begin
      pend.push_back('{addr: mem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      inflight++;
      check("credit_bound", {31'b0, (inflight <= FIFO_DEPTH)}, 32'd1);
    end

    prev_stall_hold = inst_valid && fetch_stall && !flush;
    prev_pc         = inst_pc;
    prev_inst       = inst;
    prev_req_hold   = mem_req_valid && !mem_req_ready && !flush;
    prev_addr       = mem_req_addr;
    post_flush_chk  = flush && (flush_pc[1:0] == 2'b00);
    if (flush) begin
      exp_pc   = flush_pc;
      exp_req  = flush_pc;
      exp_mis  = (flush_pc[1:0] != 2'b00);
      exp_done = 0;
    end
  endtask

  task automatic step();
    pend_t r;
    @(posedge clk);
    #1;
    cyc++;
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    mem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(r.addr);
      mem_resp_error = err_en && (r.addr == err_addr);
      inflight--;
      if (first_resp_cyc < 0) first_resp_cyc = cyc;
    end
    mem_req_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
    fetch_stall   = stall_force || (rand_stall && $urandom_range(3, 0) == 0);
    flush         = flush_req;
    flush_pc      = flush_tgt;
    flush_req     = 0;
    #3;
    sample();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    flush          = 1'b0;
    fetch_stall    = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_exc_valid", {31'b0, exception_valid_out}, 32'd0);
    check("rst_exc_num", {26'b0, exception_num_out}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_deliv(input int k, input int budget, input string tag);
    int n0 = n_deliv;
    for (int i = 0; i < budget && (n_deliv - n0) < k; i++) step();
    check(tag, {31'b0, ((n_deliv - n0) >= k)}, 32'd1);
  endtask

  task automatic run_done(input int budget, input string tag);
    for (int i = 0; i < budget && !exp_done; i++) step();
    check(tag, {31'b0, exp_done}, 32'd1);
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_req = 1;
    flush_tgt = tgt;
    step();
  endtask

  initial begin
    // 1: reset release, sequential fetch, response-to-valid latency
    do_reset();
    run_deliv(2, 20, "t1_progress");
    check("t1_latency", first_iv_cyc - first_resp_cyc, EXP_LAT);
    check("t1_back_to_back", deliv_cyc[1] - deliv_cyc[0], 32'd1);

    // 2: decode stall fills the buffer and blocks issue; release delivers in order
    stall_force = 1;
    repeat (4) step();
    check("t2_req_blocked", {31'b0, mem_req_valid}, 32'd0);
    check("t2_head_valid", {31'b0, inst_valid}, 32'd1);
    stall_force = 0;
    run_deliv(2, 20, "t2_release");

    // 3: flush with two requests outstanding; stale responses must vanish
    nop_mode = 0;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 30 && inflight < 2; i++) step();
    check("t3_two_outstanding", inflight, 32'd2);
    do_flush(32'h0000_0100);
    run_deliv(1, 30, "t3_progress");
    check("t3_first_pc", last_deliv_pc, 32'h0000_0100);

    // 4: access fault on 0x8 halts issue until the next flush
    lat_min = 1;
    lat_max = 1;
    err_en = 1;
    err_addr = 32'h0000_0008;
    do_flush(32'h0000_0000);
    run_done(40, "t4_fault_delivered");
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_halt_no_req", {31'b0, mem_req_valid}, 32'd0);
    end

    // 5: misaligned redirect yields one exception entry and no memory traffic
    do_flush(32'h0000_0102);
    run_done(10, "t5_mis_delivered");
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_halt_no_req", {31'b0, mem_req_valid}, 32'd0);
    end
    err_en = 0;

    // PC wrap at the top of the address space
    do_flush(32'hFFFF_FFF8);
    run_deliv(4, 40, "wrap_progress");
    check("wrap_last_pc", last_deliv_pc, 32'h0000_0004);

    // Randomized traffic: stalls, backpressure, variable latency, random redirects
    rand_ready = 1;
    rand_stall = 1;
    lat_max = 4;
    begin
      int n0 = n_deliv;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(39, 0) == 0) begin
          flush_req = 1;
          flush_tgt = $urandom();
          if ($urandom_range(3, 0) != 0) flush_tgt[1:0] = 2'b00;
        end
        step();
      end
      check("rand_progress", {31'b0, (n_deliv - n0 > 50)}, 32'd1);
    end

    // 6: reset while responses are pending, then restart at RESET_PC
    flush_req = 1;
    flush_tgt = 32'h0000_0400;
    for (int i = 0; i < 50 && !(pend.size() > 0 && !flush_req); i++) step();
    check("t6_pending", {31'b0, (pend.size() > 0)}, 32'd1);
    do_reset();
    rand_ready = 0;
    rand_stall = 0;
    lat_max = 1;
    run_deliv(2, 20, "t6_restart");
    check("t6_restart_pc", last_deliv_pc, RESET_PC + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
